// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit over a word-wide, registered-read data memory
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses respond with resp_err)
module load_store_unit #(
  parameter int ADDR_SIZE = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_read_addr,
  input  logic [31:0] mem_read_data,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable
);

  typedef enum logic [1:0] {IDLE, LOAD_DATA, STORE_MERGE, RESP} state_t;

  // Only bits [ADDR_SIZE:2] reach the memory; byte lanes are handled here.
  localparam logic [31:0] ADDR_MASK = ((32'd1 << (ADDR_SIZE + 1)) - 32'd1) & ~32'd3;

  state_t      state;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [31:0] wdata_q;

  logic        funct_ok;
  logic        misalign_err;
  logic        req_err;
  logic        accept;
  logic        word_store;
  logic [31:0] eff_addr;
  logic [31:0] mem_addr_sel;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] lane_mask;
  logic [31:0] wdata_rep;
  logic [31:0] merged;

  // Loads allow 000,001,010,100,101; stores allow 000,001,010.
  assign funct_ok = req_we ? (!req_funct3[2] && (req_funct3[1:0] != 2'b11))
                           : ((req_funct3 != 3'b011) && (req_funct3[2:1] != 2'b11));

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_err = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign eff_addr     = req_addr;
`else
  assign misalign_err = 1'b0;
  always_comb begin
    eff_addr = req_addr;
    if (req_funct3[1:0] == 2'b01) eff_addr[0] = 1'b0;
    else if (req_funct3[1:0] == 2'b10) eff_addr[1:0] = 2'b00;
  end
`endif

  assign req_err    = !funct_ok || misalign_err;
  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign word_store = req_we && (req_funct3 == 3'b010);

  assign mem_addr_sel   = (state == IDLE) ? eff_addr : addr_q;
  assign mem_read_addr  = mem_addr_sel & ADDR_MASK;
  assign mem_write_addr = mem_addr_sel & ADDR_MASK;

  // Word stores go straight out in the accept cycle; sub-word stores wait for the read-modify-write.
  assign mem_write_enable = !rst &&
                            ((accept && word_store && !req_err) ||
                             ((state == STORE_MERGE) && we_q));
  assign mem_write_data   = (state == IDLE) ? req_wdata : merged;

  assign shifted = mem_read_data >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = mem_read_data;
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = mem_read_data;
    endcase
  end

  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    wdata_rep = wdata_q;
    if (funct3_q[1:0] == 2'b00) begin
      lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
      wdata_rep = {4{wdata_q[7:0]}};
    end else if (funct3_q[1:0] == 2'b01) begin
      lane_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
      wdata_rep = {2{wdata_q[15:0]}};
    end
    merged = (mem_read_data & ~lane_mask) | (wdata_rep & lane_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= 32'd0;
      funct3_q   <= 3'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q   <= eff_addr;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            wdata_q  <= req_wdata;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (word_store) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else if (req_we) begin
              state <= STORE_MERGE;
            end else begin
              state <= LOAD_DATA;
            end
          end
        end
        LOAD_DATA: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        STORE_MERGE: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed table-driven bench for load_store_unit with a word memory model
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_read_addr;
  logic [31:0] mem_read_data;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.ADDR_SIZE(7)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_write_addr[7:2]] <= mem_write_data;
    mem_read_data <= mem[mem_read_addr[7:2]];
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_nwr;
    int          exp_wcyc;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request and observes up to 6 cycles for its response and any memory writes.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int nwr, output int wcyc, output logic [31:0] wdat);
    rdata = 32'hX; err = 1'bX; lat = 0; nwr = 0; wcyc = -1; wdat = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    #1;
    chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    if (mem_write_enable) begin nwr++; wcyc = 0; wdat = mem_write_data; end
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      if (mem_write_enable) begin nwr++; wcyc = c; wdat = mem_write_data; end
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
    @(negedge clk);
    #1;
    chk({tag, " resp_one_cycle"}, {30'd0, resp_valid, resp_err}, 32'd0);
  endtask

  logic [31:0] g_rdata, g_wdat;
  logic        g_err;
  int          g_lat, g_nwr, g_wcyc;
  int          bad;
  logic [31:0] exp_w20;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[4] = 32'h8899AABB;
    mem[8] = 32'h11223344;

    //          we  f3      addr   wdata         rdata         err lat nwr wcyc wdata
    vecs.push_back('{1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 0, -1, 32'h0});
    vecs.push_back('{1'b0, 3'b101, 32'h12, 32'h0,        32'h00008899, 1'b0, 2, 0, -1, 32'h0});
    vecs.push_back('{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8899, 1'b0, 2, 0, -1, 32'h0});
    vecs.push_back('{1'b0, 3'b100, 32'h10, 32'h0,        32'h000000BB, 1'b0, 2, 0, -1, 32'h0});
    vecs.push_back('{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF88, 1'b0, 2, 0, -1, 32'h0});
    vecs.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'h8899AABB, 1'b0, 2, 0, -1, 32'h0});
    vecs.push_back('{1'b1, 3'b000, 32'h22, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 1,  32'h11EF3344});
    vecs.push_back('{1'b0, 3'b010, 32'h20, 32'h0,        32'h11EF3344, 1'b0, 2, 0, -1, 32'h0});
    vecs.push_back('{1'b1, 3'b010, 32'h04, 32'hCAFEF00D, 32'h0,        1'b0, 1, 1, 0,  32'hCAFEF00D});
    vecs.push_back('{1'b0, 3'b010, 32'h04, 32'h0,        32'hCAFEF00D, 1'b0, 2, 0, -1, 32'h0});
    vecs.push_back('{1'b1, 3'b001, 32'h06, 32'h0000BEEF, 32'h0,        1'b0, 2, 1, 1,  32'hBEEFF00D});
    vecs.push_back('{1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0});
    vecs.push_back('{1'b0, 3'b110, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0});
    vecs.push_back('{1'b1, 3'b100, 32'h10, 32'h12345678, 32'h0,        1'b1, 1, 0, -1, 32'h0});
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back('{1'b0, 3'b010, 32'h06, 32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0});
    vecs.push_back('{1'b0, 3'b001, 32'h13, 32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0});
    vecs.push_back('{1'b1, 3'b001, 32'h21, 32'h00005566, 32'h0,        1'b1, 1, 0, -1, 32'h0});
    exp_w20 = 32'h11EF3344;
`else
    vecs.push_back('{1'b0, 3'b010, 32'h06, 32'h0,        32'hBEEFF00D, 1'b0, 2, 0, -1, 32'h0});
    vecs.push_back('{1'b0, 3'b001, 32'h13, 32'h0,        32'hFFFF8899, 1'b0, 2, 0, -1, 32'h0});
    vecs.push_back('{1'b1, 3'b001, 32'h21, 32'h00005566, 32'h0,        1'b0, 2, 1, 1,  32'h11EF5566});
    exp_w20 = 32'h11EF5566;
`endif
    vecs.push_back('{1'b0, 3'b010, 32'h20, 32'h0,        exp_w20,      1'b0, 2, 0, -1, 32'h0});

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_we", {31'd0, mem_write_enable}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);

    foreach (vecs[i]) begin
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, $sformatf("v%0d", i),
              g_rdata, g_err, g_lat, g_nwr, g_wcyc, g_wdat);
      chk($sformatf("v%0d latency", i), g_lat, vecs[i].exp_lat);
      chk($sformatf("v%0d rdata", i), g_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d err", i), {31'd0, g_err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d writes", i), g_nwr, vecs[i].exp_nwr);
      if (vecs[i].exp_nwr > 0) begin
        chk($sformatf("v%0d write_cycle", i), g_wcyc, vecs[i].exp_wcyc);
        chk($sformatf("v%0d write_data", i), g_wdat, vecs[i].exp_wdata);
      end
    end

    // Reset while a half store sits in STORE_MERGE: the write and response must vanish.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h20; req_wdata = 32'h00007777;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    #1;
    chk("rst_merge_we", {31'd0, mem_write_enable}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_merge_ready", {31'd0, req_ready}, 32'd1);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (resp_valid || mem_write_enable) bad++;
    end
    chk("rst_merge_quiet", bad, 0);
    run_req(1'b0, 3'b010, 32'h20, 32'h0, "post_rst_lw", g_rdata, g_err, g_lat, g_nwr, g_wcyc, g_wdat);
    chk("post_rst_lw rdata", g_rdata, exp_w20);
    chk("post_rst_lw latency", g_lat, 2);

    // Reset while a load sits in LOAD_DATA: no response may follow.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (resp_valid) bad++;
    end
    chk("rst_load_quiet", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 7, top bit of the byte address forwarded to data memory (word index = addr[ADDR_SIZE:2]).
REQ-002 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req_valid/req_ready  input/output  1/1  core request handshake.
REQ-005 SHALL have ports req_we  input  1 (1 = store), req_funct3  input  3 (RV32I load/store funct3), req_addr  input  32, req_wdata  input  32.
REQ-006 SHALL have ports resp_valid  output  1, resp_rdata  output  32, resp_err  output  1.
REQ-007 SHALL have ports mem_read_addr  output  32, mem_read_data  input  32, mem_write_addr  output  32, mem_write_data  output  32, mem_write_enable  output  1, to the word-wide data memory (registered read, 1-cycle latency, write on posedge when enabled).

Function
REQ-008 SHALL implement FSM states IDLE, LOAD_DATA, STORE_MERGE, RESP.
REQ-009 SHALL assert req_ready=1 only in IDLE; request accepted on req_valid&&req_ready.
REQ-010 SHALL latch addr, funct3, we, wdata on acceptance.
REQ-011 SHALL drive mem_read_addr combinationally from req_addr in IDLE, from the latched address otherwise.
REQ-012 Load accept: IDLE->LOAD_DATA; in LOAD_DATA extract byte/half at addr[1:0] from mem_read_data, sign-extend (LB 000, LH 001) or zero-extend (LBU 100, LHU 101), LW 010 whole word; register into resp_rdata; ->RESP.
REQ-013 SW accept: assert mem_write_enable in the acceptance cycle with mem_write_addr=req_addr, mem_write_data=req_wdata; IDLE->RESP.
REQ-014 SB/SH accept: issue read in acceptance cycle; IDLE->STORE_MERGE; in STORE_MERGE assert mem_write_enable with merged word (only addressed lanes replaced by wdata[7:0]/wdata[15:0], others from mem_read_data) at latched address; ->RESP.
REQ-015 mem_write_enable SHALL be 0 in every other cycle.
REQ-016 RESP: resp_valid=1 for exactly one cycle, ->IDLE; resp_rdata=0 for stores.
REQ-017 Latency accept->resp_valid: load 2 cycles, SW 1 cycle, SB/SH 2 cycles; one request in flight max.
REQ-018 Invalid funct3 (load 011/11x, store not in 000-010) SHALL perform no memory access, go IDLE->RESP with resp_err=1, resp_rdata=0.
REQ-019 resp_err SHALL be 0 in responses to valid accesses and 0 when resp_valid=0.

Reset
REQ-020 On rst: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, latched request cleared, mem_write_enable=0 in that cycle.
REQ-021 rst mid-operation (LOAD_DATA/STORE_MERGE/RESP) SHALL abort: no write, no response.
REQ-022 req_ready SHALL be 1 the first cycle after rst deasserts.

Configuration
REQ-023 With LSU_MISALIGN_TRAP_EN defined: half access with addr[0]=1 or word access with addr[1:0]!=0 SHALL perform no memory access and respond (IDLE->RESP) with resp_err=1.
REQ-024 Without LSU_MISALIGN_TRAP_EN: misaligned low bits SHALL be forced to 0 (half: addr[0], word: addr[1:0]) and the access performed normally; misalignment never sets resp_err.

Verification
REQ-025 Word 0x10 = 0x8899AABB; LB addr 0x11 -> resp_valid 2 cycles after accept, resp_rdata=0xFFFFFFAA, err=0.
REQ-026 Same word; LHU addr 0x12 -> resp_rdata=0x00008899; LH addr 0x12 -> 0xFFFF8899.
REQ-027 Word 0x20 = 0x11223344; SB addr 0x22 wdata 0xDEADBEEF -> one write, data 0x11EF3344; subsequent LW 0x20 returns 0x11EF3344.
REQ-028 SW addr 0x04 wdata 0xCAFEF00D -> mem_write_enable in accept cycle, resp_valid next cycle, LW 0x04 = 0xCAFEF00D.
REQ-029 LW addr 0x06: with LSU_MISALIGN_TRAP_EN -> resp_err=1, no mem write, resp_rdata=0; without -> reads word 0x04, err=0.
REQ-030 SH accepted, rst asserted in STORE_MERGE -> mem_write_enable stays 0, no resp_valid, req_ready=1 after rst drops; funct3=011 load -> resp_err=1 after 1 cycle.
